// File: rtl/routing_checker_mp.sv
// CQ routing checker: decodes the SOP beat of each CQ packet, picks a DSP port, LOCAL or UR, and holds that choice for the whole packet.
// 1-cycle latency through a 2-entry skid buffer. s_axis_cq_tready drops only while the skid slot is full; UR packets are optionally consumed.
module routing_checker_mp #(
    parameter int IF_WIDTH       = 512,
    parameter int CQ_TUSER_WIDTH = 231,
    parameter int TKEEP_WIDTH    = 16,
    parameter int NUM_DSP        = 4,
    parameter int DROP_UR        = 1,
    parameter int SEL_W          = $clog2(NUM_DSP + 2)
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [IF_WIDTH-1:0]       s_axis_cq_tdata,
    input  logic [TKEEP_WIDTH-1:0]    s_axis_cq_tkeep,
    input  logic                      s_axis_cq_tlast,
    input  logic [CQ_TUSER_WIDTH-1:0] s_axis_cq_tuser,
    input  logic                      s_axis_cq_tvalid,
    output logic                      s_axis_cq_tready,
    input  logic                      user_lnk_up,
    input  logic                      bus_num_rdy,
    input  logic [7:0]                pri_bus,
    input  logic [8*NUM_DSP-1:0]      sec_bus,
    input  logic [8*NUM_DSP-1:0]      sub_bus,
    input  logic [NUM_DSP-1:0]        port_en,
    output logic [IF_WIDTH-1:0]       m_axis_cq_tdata,
    output logic [TKEEP_WIDTH-1:0]    m_axis_cq_tkeep,
    output logic                      m_axis_cq_tlast,
    output logic [CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
    output logic                      m_axis_cq_tvalid,
    input  logic                      m_axis_cq_tready,
    output logic [SEL_W-1:0]          m_select,
    output logic                      m_unsupported_req,
    output logic                      ur_event,
    output logic [15:0]               ur_count
);

    localparam logic [SEL_W-1:0] SEL_LOCAL = SEL_W'(NUM_DSP);
    localparam logic [SEL_W-1:0] SEL_UR    = SEL_W'(NUM_DSP + 1);

    typedef struct packed {
        logic [IF_WIDTH-1:0]       tdata;
        logic [TKEEP_WIDTH-1:0]    tkeep;
        logic                      tlast;
        logic [CQ_TUSER_WIDTH-1:0] tuser;
        logic [SEL_W-1:0]          sel;
        logic                      ur;
    } beat_t;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] pkt_sel_q, pkt_sel_d;
    beat_t            out_q, out_d, skid_q, skid_d;
    logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic             ur_event_q, ur_event_d;
    logic [15:0]      ur_count_q, ur_count_d;

    logic [3:0]       req_type;
    logic [7:0]       tgt_bus, tgt_devfn;
    logic             is_cfg, dsp_hit, in_acc, push;
    logic [SEL_W-1:0] dsp_idx, sop_sel, cur_sel;
    beat_t            in_beat;

    assign req_type  = s_axis_cq_tdata[78:75];
    assign tgt_bus   = s_axis_cq_tdata[119:112];
    assign tgt_devfn = s_axis_cq_tdata[111:104];
    assign is_cfg    = (req_type[3:2] == 2'b10);

    // Descending scan so the lowest matching port index is the one left standing.
    always_comb begin
        dsp_hit = 1'b0;
        dsp_idx = '0;
        for (int i = NUM_DSP - 1; i >= 0; i--) begin
            if (port_en[i] && (sec_bus[8*i +: 8] <= tgt_bus) && (tgt_bus <= sub_bus[8*i +: 8])) begin
                dsp_hit = 1'b1;
                dsp_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sop_sel = SEL_UR;
        if (!user_lnk_up)               sop_sel = SEL_UR;
        else if (!bus_num_rdy)          sop_sel = SEL_LOCAL;
        else if (!is_cfg)               sop_sel = SEL_LOCAL;
        else if (tgt_bus == pri_bus)    sop_sel = (tgt_devfn == 8'd0) ? SEL_LOCAL : SEL_UR;
        else if (dsp_hit)               sop_sel = dsp_idx;
        else                            sop_sel = SEL_UR;
    end

    assign s_axis_cq_tready = ~skid_vld_q & ~user_reset;
    assign in_acc  = s_axis_cq_tvalid & s_axis_cq_tready;
    assign cur_sel = (state_q == IDLE) ? sop_sel : pkt_sel_q;
    assign push    = in_acc & ~((DROP_UR != 0) && (cur_sel == SEL_UR));

    always_comb begin
        in_beat.tdata = s_axis_cq_tdata;
        in_beat.tkeep = s_axis_cq_tkeep;
        in_beat.tlast = s_axis_cq_tlast;
        in_beat.tuser = s_axis_cq_tuser;
        in_beat.sel   = cur_sel;
        in_beat.ur    = (cur_sel == SEL_UR);
    end

    always_comb begin
        state_d    = state_q;
        pkt_sel_d  = pkt_sel_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        ur_event_d = 1'b0;
        ur_count_d = ur_count_q;

        if (in_acc) begin
            if (state_q == IDLE) begin
                if (!s_axis_cq_tlast) begin
                    state_d   = IN_PKT;
                    pkt_sel_d = sop_sel;
                end
            end else if (s_axis_cq_tlast) begin
                state_d = IDLE;
            end
            if (s_axis_cq_tlast && (cur_sel == SEL_UR)) begin
                ur_event_d = 1'b1;
                if (ur_count_q != 16'hFFFF) ur_count_d = ur_count_q + 16'd1;
            end
        end

        // Skid slot refills the output first; tready is low while it is full, so no push collides.
        if (!out_vld_q || m_axis_cq_tready) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_d     = push ? in_beat : out_q;
                out_vld_d = push;
            end
        end else if (push) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q    <= IDLE;
            pkt_sel_q  <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            ur_event_q <= 1'b0;
            ur_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pkt_sel_q  <= pkt_sel_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            ur_event_q <= ur_event_d;
            ur_count_q <= ur_count_d;
        end
    end

    assign m_axis_cq_tdata   = out_q.tdata;
    assign m_axis_cq_tkeep   = out_q.tkeep;
    assign m_axis_cq_tlast   = out_q.tlast;
    assign m_axis_cq_tuser   = out_q.tuser;
    assign m_axis_cq_tvalid  = out_vld_q;
    assign m_select          = out_q.sel;
    assign m_unsupported_req = out_q.ur;
    assign ur_event          = ur_event_q;
    assign ur_count          = ur_count_q;

endmodule

// File: tb/tb_routing_checker_mp.sv
// Bench for routing_checker_mp: queue-based reference model checked every cycle, directed routing cases and a random backpressure run.
module tb_routing_checker_mp;

    localparam int IFW = 512, TUW = 231, TKW = 16, ND = 4, SW = 3;

    logic            clk = 1'b0;
    logic            user_reset = 1'b1;
    logic [IFW-1:0]  s_tdata = '0;
    logic [TKW-1:0]  s_tkeep = '0;
    logic            s_tlast = 1'b0;
    logic [TUW-1:0]  s_tuser = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic            lnk_up = 1'b1, bus_rdy = 1'b1;
    logic [7:0]      pri_bus = 8'd1;
    logic [8*ND-1:0] sec_bus = '0, sub_bus = '0;
    logic [ND-1:0]   port_en = '0;
    logic [IFW-1:0]  m_tdata;
    logic [TKW-1:0]  m_tkeep;
    logic            m_tlast, m_tvalid;
    logic [TUW-1:0]  m_tuser;
    logic            m_tready = 1'b1;
    logic [SW-1:0]   m_select;
    logic            m_ur, ur_event;
    logic [15:0]     ur_count;

    routing_checker_mp #(.IF_WIDTH(IFW), .CQ_TUSER_WIDTH(TUW), .TKEEP_WIDTH(TKW), .NUM_DSP(ND), .DROP_UR(1)) dut (
        .user_clk(clk), .user_reset(user_reset),
        .s_axis_cq_tdata(s_tdata), .s_axis_cq_tkeep(s_tkeep), .s_axis_cq_tlast(s_tlast),
        .s_axis_cq_tuser(s_tuser), .s_axis_cq_tvalid(s_tvalid), .s_axis_cq_tready(s_tready),
        .user_lnk_up(lnk_up), .bus_num_rdy(bus_rdy), .pri_bus(pri_bus),
        .sec_bus(sec_bus), .sub_bus(sub_bus), .port_en(port_en),
        .m_axis_cq_tdata(m_tdata), .m_axis_cq_tkeep(m_tkeep), .m_axis_cq_tlast(m_tlast),
        .m_axis_cq_tuser(m_tuser), .m_axis_cq_tvalid(m_tvalid), .m_axis_cq_tready(m_tready),
        .m_select(m_select), .m_unsupported_req(m_ur), .ur_event(ur_event), .ur_count(ur_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [IFW-1:0] data;
        logic [TKW-1:0] keep;
        logic           last;
        logic [TUW-1:0] user;
        int             sel;
    } exp_t;

    exp_t   expq[$];
    int     vectors = 0, miscompares = 0;
    bit     in_pkt = 0;
    int     pkt_sel = 0;
    bit     exp_evt = 0;
    int     exp_cnt = 0;
    int     last_sel = -1, prev_sel = -1, evt_seen = 0;
    bit     rnd_rdy = 0;

    task automatic check(input string name, input logic [IFW-1:0] got, input logic [IFW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Routing rules, first match wins; 4 = LOCAL, 5 = UR.
    function automatic int route(input bit lnk, input bit rdy, input logic [3:0] rt, input logic [7:0] bus,
                                 input logic [7:0] dfn, input logic [7:0] pri, input logic [8*ND-1:0] sec,
                                 input logic [8*ND-1:0] sub, input logic [ND-1:0] en);
        if (!lnk) return ND + 1;
        if (!rdy) return ND;
        if (rt[3:2] != 2'b10) return ND;
        if (bus == pri) return (dfn == 8'd0) ? ND : ND + 1;
        for (int i = 0; i < ND; i++)
            if (en[i] && sec[8*i +: 8] <= bus && bus <= sub[8*i +: 8]) return i;
        return ND + 1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   sel;
        check("m_tvalid", m_tvalid, expq.size() > 0);
        check("s_tready", s_tready, (!user_reset && expq.size() < 2));
        check("ur_event", ur_event, exp_evt);
        check("ur_count", ur_count, exp_cnt);
        if (m_tvalid && expq.size() > 0) begin
            check("tdata", m_tdata, expq[0].data);
            check("tkeep", m_tkeep, expq[0].keep);
            check("tlast", m_tlast, expq[0].last);
            check("tuser", m_tuser, expq[0].user);
            check("m_select", m_select, expq[0].sel);
            check("m_ur", m_ur, expq[0].sel == ND + 1);
        end
        if (ur_event && !user_reset) evt_seen++;
        if (user_reset) begin
            expq.delete();
            in_pkt = 0; exp_evt = 0; exp_cnt = 0;
        end else begin
            if (m_tvalid && m_tready && expq.size() > 0) begin
                prev_sel = last_sel;
                last_sel = expq[0].sel;
                void'(expq.pop_front());
            end
            exp_evt = 0;
            if (s_tvalid && s_tready) begin
                if (!in_pkt) begin
                    sel = route(lnk_up, bus_rdy, s_tdata[78:75], s_tdata[119:112], s_tdata[111:104],
                                pri_bus, sec_bus, sub_bus, port_en);
                    pkt_sel = sel;
                    in_pkt = !s_tlast;
                end else begin
                    sel = pkt_sel;
                    if (s_tlast) in_pkt = 0;
                end
                if (sel != ND + 1) begin
                    e.data = s_tdata; e.keep = s_tkeep; e.last = s_tlast; e.user = s_tuser; e.sel = sel;
                    expq.push_back(e);
                end else if (s_tlast) begin
                    exp_evt = 1;
                    if (exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [IFW-1:0] rnd_vec();
        logic [IFW-1:0] r;
        for (int i = 0; i < IFW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic send_pkt(input int nb, input int stop, input logic [3:0] rt, input logic [7:0] bus,
                            input logic [7:0] dfn, input bit chg);
        logic [IFW-1:0] d, u;
        bit hs;
        int n;
        for (int b = 0; b < stop; b++) begin
            d = rnd_vec(); u = rnd_vec();
            if (b == 0) begin d[78:75] = rt; d[119:112] = bus; d[111:104] = dfn; end
            s_tdata = d; s_tuser = u[TUW-1:0]; s_tkeep = TKW'($urandom);
            s_tlast = (b == nb - 1); s_tvalid = 1'b1;
            n = 0; hs = 0;
            while (!hs && n < 200) begin
                @(negedge clk); hs = s_tready;
                @(posedge clk); #1; n++;
            end
            if (!hs) begin
                miscompares++;
                $display("FAIL accept_timeout: got no s_tready, want acceptance within 200 cycles");
                s_tvalid = 1'b0;
                return;
            end
            if (chg) port_en = ND'($urandom);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin @(negedge clk); n++; end while ((m_tvalid || s_tvalid) && n < 200);
        if (n >= 200) begin
            miscompares++;
            $display("FAIL drain_timeout: got m_tvalid=%0b, want 0 within 200 cycles", m_tvalid);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cfg_base();
        lnk_up = 1; bus_rdy = 1; pri_bus = 8'd1; port_en = 4'b1111;
        sec_bus = {8'd60, 8'd5, 8'd40, 8'd20};
        sub_bus = {8'd70, 8'd8, 8'd50, 8'd30};
    endtask

    initial begin
        int beats;
        cfg_base();
        repeat (3) @(posedge clk);
        #1 user_reset = 0;

        check("pin_route_dsp2", route(1, 1, 4'b1000, 8'd7, 8'd0, 8'd1, {8'd60, 8'd5, 8'd40, 8'd20}, {8'd70, 8'd8, 8'd50, 8'd30}, 4'hF), 2);
        check("pin_route_ur", route(1, 1, 4'b1000, 8'd1, 8'd8, 8'd1, '0, '0, 4'hF), 5);
        check("pin_route_mem", route(1, 1, 4'b0000, 8'd7, 8'd0, 8'd1, '0, '0, 4'hF), 4);

        // T1: cfg read to bus 7 lands on port 2 for all three beats
        send_pkt(3, 3, 4'b1000, 8'd7, 8'd0, 0);
        wait_drain();
        check("t1_sel", last_sel, 2);

        // T2: own bus dev/fn 0 is LOCAL; nonzero dev/fn is UR and dropped
        send_pkt(2, 2, 4'b1000, 8'd1, 8'd0, 0);
        wait_drain();
        check("t2_local", last_sel, 4);
        send_pkt(2, 2, 4'b1000, 8'd1, 8'd8, 0);
        wait_drain();
        check("t2_ur_cnt", ur_count, 1);
        check("t2_evt", evt_seen, 1);
        check("t2_no_fwd", last_sel, 4);

        // T3: overlapping windows, lowest enabled port wins
        sec_bus = {8'd5, 8'd120, 8'd100, 8'd5};
        sub_bus = {8'd9, 8'd130, 8'd110, 8'd9};
        send_pkt(2, 2, 4'b1001, 8'd7, 8'd3, 0);
        wait_drain();
        check("t3_port0", last_sel, 0);
        port_en[0] = 1'b0;
        send_pkt(2, 2, 4'b1001, 8'd7, 8'd3, 0);
        wait_drain();
        check("t3_port3", last_sel, 3);

        // T5: bus numbers not ready -> LOCAL; link down -> UR; single-beat packets back to back
        cfg_base();
        bus_rdy = 0;
        send_pkt(1, 1, 4'b1000, 8'd200, 8'd0, 0);
        wait_drain();
        check("t5_local", last_sel, 4);
        bus_rdy = 1; lnk_up = 0;
        send_pkt(1, 1, 4'b1000, 8'd7, 8'd0, 0);
        wait_drain();
        check("t5_ur_cnt", ur_count, 2);
        lnk_up = 1;
        send_pkt(1, 1, 4'b1000, 8'd7, 8'd0, 0);
        send_pkt(1, 1, 4'b1000, 8'd1, 8'd0, 0);
        wait_drain();
        check("t5_first", prev_sel, 2);
        check("t5_second", last_sel, 4);

        // T6: reset on beat 2 of a 4-beat packet
        send_pkt(4, 2, 4'b1000, 8'd1, 8'd0, 0);
        user_reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("t6_tvalid", m_tvalid, 0);
        check("t6_ur_cnt", ur_count, 0);
        user_reset = 0;
        send_pkt(2, 2, 4'b1000, 8'd7, 8'd0, 0);
        wait_drain();
        check("t6_sop", last_sel, 2);

        // T4: random packets with random downstream backpressure and mid-packet config churn
        rnd_rdy = 1;
        beats = 0;
        while (beats < 1000) begin
            int nb;
            nb = $urandom_range(1, 6);
            lnk_up  = ($urandom_range(0, 19) != 0);
            bus_rdy = ($urandom_range(0, 9) != 0);
            port_en = ND'($urandom);
            send_pkt(nb, nb, 4'($urandom), ($urandom_range(0, 3) == 0) ? 8'd1 : 8'($urandom_range(0, 80)),
                     ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom), 1);
            beats += nb;
        end
        rnd_rdy = 0;
        wait_drain();
        check("t4_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
